// File: rtl/eth_log_arbiter.sv
// Two-source log stream arbiter: packet-locked round-robin merge of AXI-Stream
// sources A and B into a single registered output with per-source packet counters.

module eth_log_src_lane (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_clear,
  input  logic        grant,
  input  logic        out_ready,
  input  logic        tvalid,
  input  logic        tlast,
  output logic        tready,
  output logic        accept,
  output logic [31:0] pkt_count
);
  assign tready = grant & out_ready;
  assign accept = tvalid & tready;

  // Clear wins over a coincident end-of-packet increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 pkt_count <= '0;
    else if (count_clear)        pkt_count <= '0;
    else if (accept && tlast)    pkt_count <= pkt_count + 32'd1;
  end
endmodule

module eth_log_arbiter #(
  parameter int C_AXIS_LOG_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        count_clear,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_a_tdata,
  input  logic                        s_axis_a_tlast,
  input  logic                        s_axis_a_tvalid,
  output logic                        s_axis_a_tready,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_b_tdata,
  input  logic                        s_axis_b_tlast,
  input  logic                        s_axis_b_tvalid,
  output logic                        s_axis_b_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tid,
  input  logic                        m_axis_tready,
  output logic [31:0]                 pkt_count_a,
  output logic [31:0]                 pkt_count_b
);
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2} state_t;

  state_t state;
  logic   last_grant;  // 1 = B served last
  logic   out_ready;

  logic [NUM_SRC-1:0]                       src_valid, src_last, src_grant, src_ready, src_acc;
  logic [NUM_SRC-1:0][C_AXIS_LOG_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0][31:0]                 src_count;

  assign src_valid = {s_axis_b_tvalid, s_axis_a_tvalid};
  assign src_last  = {s_axis_b_tlast,  s_axis_a_tlast};
  assign src_data  = {s_axis_b_tdata,  s_axis_a_tdata};
  assign src_grant = {state == GRANT_B, state == GRANT_A};
  assign out_ready = ~m_axis_tvalid | m_axis_tready;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
      eth_log_src_lane u_lane (
        .clk        (clk),
        .resetn     (resetn),
        .count_clear(count_clear),
        .grant      (src_grant[i]),
        .out_ready  (out_ready),
        .tvalid     (src_valid[i]),
        .tlast      (src_last[i]),
        .tready     (src_ready[i]),
        .accept     (src_acc[i]),
        .pkt_count  (src_count[i])
      );
    end
  endgenerate

  assign s_axis_a_tready = src_ready[0];
  assign s_axis_b_tready = src_ready[1];
  assign pkt_count_a     = src_count[0];
  assign pkt_count_b     = src_count[1];

  // Grant is held for a whole packet; returning through IDLE gives one bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (enable) begin
          if (src_valid[0] && src_valid[1]) state <= last_grant ? GRANT_A : GRANT_B;
          else if (src_valid[0])            state <= GRANT_A;
          else if (src_valid[1])            state <= GRANT_B;
        end
        GRANT_A: if (src_acc[0] && src_last[0]) begin
          state      <= IDLE;
          last_grant <= 1'b0;
        end
        GRANT_B: if (src_acc[1] && src_last[1]) begin
          state      <= IDLE;
          last_grant <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= 1'b0;
    end else if (|src_acc) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tid    <= src_acc[1];
      m_axis_tdata  <= src_acc[1] ? src_data[1] : src_data[0];
      m_axis_tlast  <= src_acc[1] ? src_last[1] : src_last[0];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_eth_log_arbiter.sv
// Scoreboard bench for eth_log_arbiter: per-source expected beat queues are
// filled when stimulus is queued and drained as beats leave m_axis.

module tb_eth_log_arbiter;
  localparam int W = 64;

  typedef struct packed {logic [W-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [W-1:0] d; logic l; logic id; logic [31:0] cyc;} obs_t;

  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, count_clear = 1'b0;
  logic [W-1:0] s_axis_a_tdata, s_axis_b_tdata, m_axis_tdata;
  logic s_axis_a_tlast, s_axis_a_tvalid, s_axis_a_tready;
  logic s_axis_b_tlast, s_axis_b_tvalid, s_axis_b_tready;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tid, m_axis_tready;
  logic [31:0] pkt_count_a, pkt_count_b;

  beat_t src_a[$], src_b[$], exp_a[$], exp_b[$];
  obs_t  out_log[$];
  logic  pkt_ids[$];
  int n_vec = 0, n_err = 0;
  logic [31:0] cyc = 0;
  bit a_go = 0, b_go = 0;
  int rdy_mode = 0, stall_cnt = 0;

  eth_log_arbiter #(.C_AXIS_LOG_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .count_clear(count_clear),
    .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_a_tvalid(s_axis_a_tvalid), .s_axis_a_tready(s_axis_a_tready),
    .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tlast(s_axis_b_tlast),
    .s_axis_b_tvalid(s_axis_b_tvalid), .s_axis_b_tready(s_axis_b_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tid(m_axis_tid),
    .m_axis_tready(m_axis_tready),
    .pkt_count_a(pkt_count_a), .pkt_count_b(pkt_count_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Source drivers + output monitor/scoreboard.
  initial begin : drv_mon
    bit a_acc, b_acc;
    beat_t e;
    bit have;
    s_axis_a_tvalid = 0; s_axis_a_tdata = '0; s_axis_a_tlast = 0;
    s_axis_b_tvalid = 0; s_axis_b_tdata = '0; s_axis_b_tlast = 0;
    m_axis_tready = 1;
    forever begin
      @(negedge clk);
      a_acc = s_axis_a_tvalid && s_axis_a_tready;
      b_acc = s_axis_b_tvalid && s_axis_b_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        n_vec++;
        have = m_axis_tid ? (exp_b.size() > 0) : (exp_a.size() > 0);
        if (!have) begin
          n_err++;
          $display("FAIL mon_unexpected: got tid=%0d data=%h last=%0d, required no beat", m_axis_tid, m_axis_tdata, m_axis_tlast);
        end else begin
          e = m_axis_tid ? exp_b.pop_front() : exp_a.pop_front();
          if ({m_axis_tdata, m_axis_tlast} !== e) begin
            n_err++;
            $display("FAIL mon_beat tid=%0d: got data=%h last=%0d, required data=%h last=%0d", m_axis_tid, m_axis_tdata, m_axis_tlast, e.d, e.l);
          end
        end
        out_log.push_back({m_axis_tdata, m_axis_tlast, m_axis_tid, cyc});
        if (m_axis_tlast) pkt_ids.push_back(m_axis_tid);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (a_acc && src_a.size() > 0) void'(src_a.pop_front());
      if (b_acc && src_b.size() > 0) void'(src_b.pop_front());
      if (a_go && src_a.size() > 0) begin
        s_axis_a_tvalid = 1; s_axis_a_tdata = src_a[0].d; s_axis_a_tlast = src_a[0].l;
      end else s_axis_a_tvalid = 0;
      if (b_go && src_b.size() > 0) begin
        s_axis_b_tvalid = 1; s_axis_b_tdata = src_b[0].d; s_axis_b_tlast = src_b[0].l;
      end else s_axis_b_tvalid = 0;
      if (stall_cnt > 0) begin
        m_axis_tready = 0; stall_cnt--;
      end else if (rdy_mode == 1) m_axis_tready = ($urandom_range(3) != 0);
      else m_axis_tready = 1;
    end
  end

  task automatic push_pkt(input bit src, input int n, input logic [W-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + W'(i);
      b.l = (i == n - 1);
      if (src) begin src_b.push_back(b); exp_b.push_back(b); end
      else     begin src_a.push_back(b); exp_a.push_back(b); end
    end
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    int k;
    for (k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (src_a.size() == 0 && src_b.size() == 0 && exp_a.size() == 0 &&
          exp_b.size() == 0 && !m_axis_tvalid) break;
    end
    if (k == maxc) begin
      n_vec++; n_err++;
      $display("FAIL %s_drain: got %0d/%0d beats pending after %0d cycles, required 0", nm, exp_a.size(), exp_b.size(), maxc);
    end
  endtask

  task automatic wait_out(input logic [W-1:0] d, input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == d) break;
    end
    if (k == 200) begin
      n_vec++; n_err++;
      $display("FAIL %s_wait: got no output beat, required data=%h", nm, d);
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tid, s_axis_a_tready, s_axis_b_tready} !== 5'b0 ||
        m_axis_tdata !== '0 || pkt_count_a !== 0 || pkt_count_b !== 0) begin
      n_err++;
      $display("FAIL reset_state: got v=%0d d=%h cnt=%0d/%0d, required all zero", m_axis_tvalid, m_axis_tdata, pkt_count_a, pkt_count_b);
    end
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    out_log.delete();
    enable = 1;
    push_pkt(0, 3, 64'hA000_0000_0000_0000);
    push_pkt(1, 3, 64'hB000_0000_0000_0000);
    a_go = 1; b_go = 1;
    wait_drain(100, "cont");
    n_vec++;
    if (out_log.size() != 6) begin
      n_err++;
      $display("FAIL cont_len: got %0d beats, required 6", out_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (out_log[i].id !== (i >= 3) || out_log[i].l !== (i % 3 == 2) ||
            out_log[i].d !== ((i < 3 ? 64'hA000_0000_0000_0000 : 64'hB000_0000_0000_0000) + W'(i % 3))) begin
          n_err++;
          $display("FAIL cont_order[%0d]: got id=%0d d=%h l=%0d, required id=%0d", i, out_log[i].id, out_log[i].d, out_log[i].l, (i >= 3));
        end
      end
      n_vec++;
      if (out_log[1].cyc != out_log[0].cyc + 1 || out_log[2].cyc != out_log[1].cyc + 1 ||
          out_log[3].cyc != out_log[2].cyc + 2 || out_log[5].cyc != out_log[3].cyc + 2) begin
        n_err++;
        $display("FAIL cont_timing: got cycles %0d %0d %0d %0d, required consecutive with one bubble", out_log[0].cyc, out_log[1].cyc, out_log[2].cyc, out_log[3].cyc);
      end
    end
    n_vec++;
    if (pkt_count_a !== 1 || pkt_count_b !== 1) begin
      n_err++;
      $display("FAIL cont_count: got %0d/%0d, required 1/1", pkt_count_a, pkt_count_b);
    end
    a_go = 0; b_go = 0;
  endtask

  task automatic test_stall();
    out_log.delete();
    push_pkt(0, 4, 64'hA100_0000_0000_0000);
    a_go = 1;
    wait_out(64'hA100_0000_0000_0001, "stall");
    stall_cnt = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (m_axis_tvalid !== 1 || m_axis_tdata !== 64'hA100_0000_0000_0002 || m_axis_tlast !== 0 ||
          m_axis_tready !== 0 || s_axis_a_tready !== 0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%0d d=%h rdy=%0d a_rdy=%0d, required v=1 d=a100..0002 rdy=0 a_rdy=0", i, m_axis_tvalid, m_axis_tdata, m_axis_tready, s_axis_a_tready);
      end
    end
    wait_drain(100, "stall");
    n_vec++;
    if (out_log.size() != 4 || pkt_count_a !== 2) begin
      n_err++;
      $display("FAIL stall_count: got %0d beats cnt=%0d, required 4 beats cnt=2", out_log.size(), pkt_count_a);
    end
    a_go = 0;
  endtask

  task automatic test_enable();
    int k;
    enable = 0;
    push_pkt(0, 2, 64'hA200_0000_0000_0000);
    push_pkt(1, 3, 64'hB200_0000_0000_0000);
    a_go = 1; b_go = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if ({s_axis_a_tready, s_axis_b_tready, m_axis_tvalid} !== 3'b000) begin
        n_err++;
        $display("FAIL en_block[%0d]: got a_rdy=%0d b_rdy=%0d v=%0d, required 0 0 0", i, s_axis_a_tready, s_axis_b_tready, m_axis_tvalid);
      end
    end
    enable = 1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_axis_b_tready || s_axis_a_tready) break;
    end
    n_vec++;
    if (s_axis_b_tready !== 1 || s_axis_a_tready !== 0) begin
      n_err++;
      $display("FAIL en_rr: got a_rdy=%0d b_rdy=%0d, required B granted", s_axis_a_tready, s_axis_b_tready);
    end
    enable = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (src_b.size() == 0 && exp_b.size() == 0 && !m_axis_tvalid) break;
    end
    n_vec++;
    if (k == 100) begin
      n_err++;
      $display("FAIL en_complete: got %0d B beats pending, required 0", exp_b.size());
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (s_axis_a_tready !== 0 || m_axis_tvalid !== 0 || src_a.size() != 2) begin
        n_err++;
        $display("FAIL en_nogrant[%0d]: got a_rdy=%0d v=%0d pend=%0d, required 0 0 2", i, s_axis_a_tready, m_axis_tvalid, src_a.size());
      end
    end
    enable = 1;
    wait_drain(100, "en");
    n_vec++;
    if (pkt_count_a !== 3 || pkt_count_b !== 2) begin
      n_err++;
      $display("FAIL en_count: got %0d/%0d, required 3/2", pkt_count_a, pkt_count_b);
    end
    a_go = 0; b_go = 0;
  endtask

  task automatic test_counters();
    int k;
    force dut.g_lane[0].u_lane.pkt_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.g_lane[0].u_lane.pkt_count;
    @(negedge clk);
    n_vec++;
    if (pkt_count_a !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_preload: got %h, required ffffffff", pkt_count_a);
    end
    push_pkt(0, 1, 64'hA300_0000_0000_0000);
    a_go = 1;
    wait_drain(50, "wrap");
    n_vec++;
    if (pkt_count_a !== 0 || pkt_count_b !== 2) begin
      n_err++;
      $display("FAIL wrap: got %h/%0d, required 0/2", pkt_count_a, pkt_count_b);
    end
    a_go = 0;
    count_clear = 1;
    push_pkt(1, 2, 64'hB300_0000_0000_0000);
    b_go = 1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_axis_b_tvalid && s_axis_b_tready && s_axis_b_tlast) break;
    end
    @(negedge clk);
    count_clear = 0;
    @(negedge clk);
    n_vec++;
    if (k == 50 || pkt_count_a !== 0 || pkt_count_b !== 0) begin
      n_err++;
      $display("FAIL clear_tlast: got %0d/%0d, required 0/0", pkt_count_a, pkt_count_b);
    end
    wait_drain(50, "clear");
    b_go = 0;
  endtask

  task automatic test_reset_mid();
    out_log.delete();
    push_pkt(0, 5, 64'hA400_0000_0000_0000);
    a_go = 1;
    wait_out(64'hA400_0000_0000_0001, "rmid");
    a_go = 0;
    #2 resetn = 0;
    #1;
    n_vec++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tid, s_axis_a_tready, s_axis_b_tready} !== 5'b0 ||
        m_axis_tdata !== '0 || pkt_count_a !== 0 || pkt_count_b !== 0) begin
      n_err++;
      $display("FAIL rmid_zero: got v=%0d d=%h a_rdy=%0d, required all zero", m_axis_tvalid, m_axis_tdata, s_axis_a_tready);
    end
    src_a.delete(); exp_a.delete();
    repeat (2) @(negedge clk);
    resetn = 1;
    out_log.delete();
    push_pkt(1, 2, 64'hB400_0000_0000_0000);
    b_go = 1;
    wait_drain(50, "rmid_b");
    push_pkt(0, 3, 64'hA500_0000_0000_0000);
    a_go = 1;
    wait_drain(50, "rmid_a");
    n_vec++;
    if (out_log.size() != 5 || out_log[0].id !== 1 || pkt_count_a !== 1 || pkt_count_b !== 1) begin
      n_err++;
      $display("FAIL rmid_after: got %0d beats first_id=%0d cnt=%0d/%0d, required 5 beats id=1 cnt=1/1", out_log.size(), out_log[0].id, pkt_count_a, pkt_count_b);
    end
    a_go = 0; b_go = 0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    pkt_ids.delete();
    for (int p = 0; p < 500; p++) begin
      push_pkt(0, $urandom_range(4, 1), {8'hAA, 24'(p), 32'($urandom) & 32'hFFFF_FF00});
      push_pkt(1, $urandom_range(4, 1), {8'hBB, 24'(p), 32'($urandom) & 32'hFFFF_FF00});
    end
    rdy_mode = 1;
    a_go = 1; b_go = 1;
    wait_drain(40000, "b2b");
    rdy_mode = 0;
    for (int i = 1; i < pkt_ids.size(); i++) if (pkt_ids[i] === pkt_ids[i-1]) bad++;
    n_vec++;
    if (pkt_ids.size() != 1000 || bad != 0 || pkt_ids[0] !== 1) begin
      n_err++;
      $display("FAIL b2b_alternate: got %0d pkts, %0d repeats, required 1000 strictly alternating from B", pkt_ids.size(), bad);
    end
    n_vec++;
    if (pkt_count_a !== 501 || pkt_count_b !== 501) begin
      n_err++;
      $display("FAIL b2b_count: got %0d/%0d, required 501/501", pkt_count_a, pkt_count_b);
    end
    a_go = 0; b_go = 0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_stall();
    test_enable();
    test_counters();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
